// File: rtl/a1p_issue_sequencer.sv
// Issue controller for the pipelined datapath: streams element indices 0..LAST into the
// pipeline head, tracks them through DEPTH free-running stages and pulses Done at the end.
module a1p_issue_sequencer #(
    parameter int COUNT_W = 6,
    parameter int LAST    = 63,
    parameter int DEPTH   = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic               Stall,
    input  logic               Abort,
    output logic [COUNT_W-1:0] Count,
    output logic               C_EX,
    output logic               OutVld,
    output logic               Busy,
    output logic               Done,
    output logic [1:0]         Dbg_state
);

    // Handshake: C_EX is a pure valid qualifying Count; the pipeline has no ready/backpressure,
    // so every cycle with C_EX=1 transfers exactly one element, and OutVld marks it at the tail.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] LAST_C = COUNT_W'(LAST);

    state_t             state_q;
    state_t             state_d;
    logic [COUNT_W-1:0] count_d;
    logic               cex_d;
    logic [DEPTH-1:0]   vld_sr;
    logic [DEPTH-1:0]   vld_d;
    logic               at_last;
    logic               pipe_clear;

    assign at_last    = C_EX && (Count == LAST_C);
    // Only the final stage may still hold the last element when DRAIN hands over to DONE.
    assign pipe_clear = (vld_sr[DEPTH-2:0] == '0);

    always_comb begin
        state_d = state_q;
        count_d = Count;
        cex_d   = 1'b0;
        if (Abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (Start) begin
                        state_d = ISSUE;
                        cex_d   = 1'b1;
                    end
                end
                ISSUE: begin
                    if (at_last) begin
                        state_d = DRAIN;
                    end else begin
                        cex_d = !Stall;
                        if (C_EX) begin
                            count_d = Count + COUNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_clear) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        vld_d = {vld_sr[DEPTH-2:0], C_EX};
        if (Abort) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            Count   <= '0;
            C_EX    <= 1'b0;
            vld_sr  <= '0;
        end else begin
            state_q <= state_d;
            Count   <= count_d;
            C_EX    <= cex_d;
            vld_sr  <= vld_d;
        end
    end

    assign OutVld    = vld_sr[DEPTH-1];
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);
    assign Dbg_state = state_q;

endmodule

// File: tb/tb_a1p_issue_sequencer.sv
// Bench for a1p_issue_sequencer: directed timing checks from the run timeline plus random
// Start/Stall/Abort traffic compared cycle by cycle against an element-counting reference model.
module tb_a1p_issue_sequencer;

    localparam int COUNT_W = 6;
    localparam int LAST    = 63;
    localparam int DEPTH   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               start, stall, abort;
    logic [COUNT_W-1:0] count;
    logic               c_ex, out_vld, busy, done;
    logic [1:0]         dbg_state;

    logic               start2;
    logic [COUNT_W-1:0] b_count;
    logic               b_cex, b_ovld, b_busy, b_done;
    logic [1:0]         b_state;

    a1p_issue_sequencer #(.COUNT_W(COUNT_W), .LAST(LAST), .DEPTH(DEPTH)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Stall(stall), .Abort(abort),
        .Count(count), .C_EX(c_ex), .OutVld(out_vld), .Busy(busy), .Done(done),
        .Dbg_state(dbg_state)
    );

    a1p_issue_sequencer #(.COUNT_W(COUNT_W), .LAST(0), .DEPTH(2)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .Start(start2), .Stall(1'b0), .Abort(1'b0),
        .Count(b_count), .C_EX(b_cex), .OutVld(b_ovld), .Busy(b_busy), .Done(b_done),
        .Dbg_state(b_state)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A run issues LAST+1 elements; Done comes DEPTH+1 cycles after the final issue.
    int   m_run, m_issued, m_fin, m_since, m_done;
    logic m_cex;
    logic hist[$];   // hist[i] = C_EX as it was i+1 cycles ago

    function automatic void model_reset();
        m_run = 0; m_issued = 0; m_fin = 0; m_since = 0; m_done = 0; m_cex = 1'b0;
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(1'b0);
    endfunction

    function automatic void model_step(input logic s, input logic st, input logic ab);
        logic prev_cex;
        prev_cex = m_cex;
        if (!rst_n || ab) begin
            model_reset();
        end else begin
            hist.push_front(prev_cex);
            void'(hist.pop_back());
            if (m_run == 0) begin
                if (s) begin
                    m_run = 1; m_cex = 1'b1; m_issued = 1; m_since = 0;
                    m_fin = (LAST == 0) ? 1 : 0;
                end
            end else if (m_done != 0) begin
                m_run = 0; m_done = 0; m_cex = 1'b0; m_issued = 0; m_fin = 0;
            end else if (m_fin != 0) begin
                m_cex = 1'b0;
                m_since++;
                m_done = (m_since == DEPTH + 1) ? 1 : 0;
            end else begin
                m_cex = !st;
                if (m_cex) begin
                    m_issued++;
                    m_since = 0;
                    m_fin = (m_issued == LAST + 1) ? 1 : 0;
                end
            end
        end
    endfunction

    function automatic int exp_count();
        if (m_run == 0) return 0;
        if (m_fin != 0) return LAST;
        return m_cex ? m_issued - 1 : m_issued;
    endfunction

    task automatic compare_all();
        check("count",  32'(count),   32'(exp_count()));
        check("c_ex",   32'(c_ex),    32'(m_cex));
        check("outvld", 32'(out_vld), 32'(hist[DEPTH-1]));
        check("busy",   32'(busy),    32'(m_run != 0));
        check("done",   32'(done),    32'(m_done != 0));
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic s, input logic st, input logic ab);
        start = s; stall = st; abort = ab;
        @(posedge clk);
        model_step(s, st, ab);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    int          done1, done2, n_ovld, n_dn, n_busy;
    logic [63:0] seen;
    logic [31:0] snap;

    task automatic run(input int ncyc, input int st_lo, input int st_hi, input int ab_at,
                       input bit hold, input bit noise);
        done1 = -1; done2 = -1; n_ovld = 0; n_dn = 0; n_busy = 0; seen = '0; snap = '1;
        cyc = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick((c == 0) || hold || (noise && ($urandom_range(0, 3) == 0)),
                 (c >= st_lo) && (c <= st_hi), c == ab_at);
            if (done) begin
                n_dn++;
                if (done1 < 0) done1 = cyc;
                else if (done2 < 0) done2 = cyc;
            end
            if (out_vld) n_ovld++;
            if (busy) n_busy++;
            if (c_ex) seen[count] = 1'b1;
            if (cyc == ab_at + 1) snap = {busy, c_ex, out_vld, done, 22'd0, 2'd0, count};
        end
    endtask

    task automatic cleanup();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; start2 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_cex",   32'(c_ex), 0);
        check("rst_ovld",  32'(out_vld), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // nominal run
        run(72, -1, -1, -1, 1'b0, 1'b0);
        check("nom_done_cyc", done1, 68);
        check("nom_ndone",    n_dn, 1);
        check("nom_ovld",     n_ovld, 64);
        check("nom_busy",     n_busy, 68);
        check("nom_seen",     $countones(seen), 64);

        // stall in cycles 10 and 11
        run(74, 10, 11, -1, 1'b0, 1'b0);
        check("stall_done_cyc", done1, 70);
        check("stall_ovld",     n_ovld, 64);
        check("stall_seen",     $countones(seen), 64);

        // abort mid-ISSUE, then a clean run
        run(100, -1, -1, 20, 1'b0, 1'b0);
        check("ab20_snap",  snap, 0);
        check("ab20_ndone", n_dn, 0);
        run(72, -1, -1, -1, 1'b0, 1'b0);
        check("ab20_rerun", done1, 68);

        // abort mid-DRAIN, then a clean run
        run(90, -1, -1, 66, 1'b0, 1'b0);
        check("ab66_snap",  snap, 0);
        check("ab66_ndone", n_dn, 0);
        run(72, -1, -1, -1, 1'b0, 1'b0);
        check("ab66_rerun", done1, 68);

        // Start held high: back-to-back runs
        run(140, -1, -1, -1, 1'b1, 1'b0);
        check("hold_done1", done1, 68);
        check("hold_done2", done2, 137);
        cleanup();

        // Start pulses while busy are ignored
        run(69, -1, -1, -1, 1'b0, 1'b1);
        check("noise_done", done1, 68);
        check("noise_nd",   n_dn, 1);
        cleanup();

        // async reset mid-DRAIN, between clock edges
        run(66, -1, -1, -1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_cex",   32'(c_ex), 0);
        check("arst_ovld",  32'(out_vld), 0);
        check("arst_busy",  32'(busy), 0);
        check("arst_done",  32'(done), 0);
        model_reset();
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        n_dn = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (done) n_dn++;
        end
        check("arst_nodone", n_dn, 0);

        // boundary instance: LAST=0, DEPTH=2
        cyc = 0;
        start2 = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        start2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("b_cex",   32'(b_cex),  32'(cyc == 1));
            check("b_count", 32'(b_count), 0);
            check("b_ovld",  32'(b_ovld), 32'(cyc == 3));
            check("b_done",  32'(b_done), 32'(cyc == 4));
            check("b_busy",  32'(b_busy), 32'((cyc >= 1) && (cyc <= 4)));
            tick(1'b0, 1'b0, 1'b0);
        end

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
